vga_frame_capture: RTL

Receive-side counterpart of the VGA timing generator: takes a pixel stream framed by hsync/vsync/data_enable plus 8-bit RGB and writes each visible pixel into the frame buffer with a linear address. It sits between a video source (timing generator output, or an external capture port) and the BRAM/SRAM frame buffer write port. It also checks frame geometry and reports lock and timing errors.

---
 rtl/vga_frame_capture_pkg.sv | 24 ++
 rtl/vga_frame_capture_sync_edge_detect.sv | 29 ++
 rtl/vga_frame_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vga_frame_capture_pkg.sv
// Shared constants and FSM encoding for the VGA capture path.
// The default timing numbers are the 640x480@60 set also used by the timing generator.
package vga_frame_capture_pkg;

  localparam int DEF_HSIZE = 640;
  localparam int DEF_HFP   = 16;
  localparam int DEF_HSP   = 96;
  localparam int DEF_HMAX  = 800;
  localparam int DEF_VSIZE = 480;
  localparam int DEF_VFP   = 10;
  localparam int DEF_VSP   = 2;
  localparam int DEF_VMAX  = 525;
  localparam int DEF_HSPP  = 0;
  localparam int DEF_VSPP  = 0;

  localparam int ADDR_W = 19;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/vga_frame_capture_sync_edge_detect.sv
// Registers one sync/enable input, normalises it to active-high and
// produces single-cycle rise/fall pulses from the registered level.
module sync_edge_detect #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= ACTIVE_HIGH ? din : ~din;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures visible pixels of a DE-framed RGB stream into a linear frame buffer
// and checks line/frame geometry, reporting lock, frame-done and error pulses.
module vga_frame_capture
  import vga_frame_capture_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int HSIZE = DEF_HSIZE,
  parameter int VSIZE = DEF_VSIZE,
  parameter int HSPP  = DEF_HSPP,
  parameter int VSPP  = DEF_VSPP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              data_enable,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [WIDTH-1:0]  hcount,
  output logic [WIDTH-1:0]  vcount,
  output logic              locked,
  output logic              frame_done,
  output logic              err
);

  // One bit wider than the address so a full 2^19 frame still compares correctly.
  localparam logic [ADDR_W:0]  FRAME_PIXELS = (ADDR_W+1)'(HSIZE * VSIZE);
  localparam logic [WIDTH-1:0] HSIZE_W      = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] VSIZE_W      = WIDTH'(VSIZE);

  logic vsync_level_unused, vsync_start, vsync_fall_unused;
  logic de_level, de_rise_unused, de_fall;
  logic hsync_s1_unused;
  logic [23:0] rgb_s1;

  sync_edge_detect #(.ACTIVE_HIGH(VSPP != 0)) u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (vsync),
    .level (vsync_level_unused),
    .rise  (vsync_start),
    .fall  (vsync_fall_unused)
  );

  sync_edge_detect #(.ACTIVE_HIGH(1'b1)) u_de_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (data_enable),
    .level (de_level),
    .rise  (de_rise_unused),
    .fall  (de_fall)
  );

  // hsync is only kept in step with the other inputs; framing relies on DE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_s1_unused <= 1'b0;
      rgb_s1          <= '0;
    end else begin
      hsync_s1_unused <= (HSPP != 0) ? hsync : ~hsync;
      rgb_s1          <= {red, green, blue};
    end
  end

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  hcount_d, vcount_d;
  logic              locked_d, wr_en_d, frame_done_d, err_d, accept;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      addr_q     <= '0;
      hcount     <= '0;
      vcount     <= '0;
      locked     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hcount     <= hcount_d;
      vcount     <= vcount_d;
      locked     <= locked_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      frame_done <= frame_done_d;
      err        <= err_d;
    end
  end

  // Frame/line events are resolved first; 'accept' then lets the same
  // stage-1 pixel be written, so a pixel coinciding with vsync lands at 0.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hcount_d     = hcount;
    vcount_d     = vcount;
    locked_d     = locked;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    accept       = 1'b0;

    case (state_q)
      SEARCH, DROP: begin
        if (vsync_start) begin
          state_d  = CAPTURE;
          addr_d   = '0;
          hcount_d = '0;
          vcount_d = '0;
          accept   = 1'b1;
        end
      end
      CAPTURE: begin
        if (vsync_start) begin
          if (vcount == VSIZE_W) begin
            frame_done_d = 1'b1;
            locked_d     = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
          addr_d   = '0;
          hcount_d = '0;
          vcount_d = '0;
          accept   = 1'b1;
        end else if (de_fall && (hcount != HSIZE_W)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = DROP;
        end else begin
          if (de_fall) begin
            hcount_d = '0;
            vcount_d = (vcount == '1) ? vcount : vcount + WIDTH'(1);
          end
          accept = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (accept && de_level) begin
      if ({1'b0, addr_d} == FRAME_PIXELS) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        state_d  = DROP;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_d;
        wr_data_d = {8'h00, rgb_s1};
        addr_d    = addr_d + ADDR_W'(1);
        hcount_d  = (hcount_d == '1) ? hcount_d : hcount_d + WIDTH'(1);
      end
    end
  end

endmodule
